// File: rtl/bus_router.sv
// Purpose: address-decoding router from one master to NUM_SLAVES slaves, with in-order read return.
// Latency: requests and write data pass combinationally; read data returns the cycle the head slave answers.
// Backpressure: ready follows the selected slave_ready; reads also stall while MAX_OUTSTANDING reads are in flight.
//
// Ports:
//   clk, reset_n                       clock (rising edge), asynchronous active-low reset
//   addr/write_data/byte_enable        master request; write_req / read_req strobes; ready handshake
//   read_data/read_data_valid          in-order read response to the master
//   slave_*                            shared address/data/enables, per-slave one-hot strobes and responses
//   error                              sticky protocol/decode error; outstanding = reads in flight
module bus_router #(
  parameter int NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = {NUM_SLAVES{32'hF000_0000}},
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  output logic                                ready,
  input  logic [31:0]                         addr,
  input  logic [31:0]                         write_data,
  input  logic [3:0]                          byte_enable,
  input  logic                                write_req,
  input  logic                                read_req,
  output logic [31:0]                         read_data,
  output logic                                read_data_valid,
  input  logic [NUM_SLAVES-1:0]               slave_ready,
  output logic [31:0]                         slave_addr,
  output logic [31:0]                         slave_write_data,
  output logic [3:0]                          slave_byte_enable,
  output logic [NUM_SLAVES-1:0]               slave_write_req,
  output logic [NUM_SLAVES-1:0]               slave_read_req,
  input  logic [32*NUM_SLAVES-1:0]            slave_read_data,
  input  logic [NUM_SLAVES-1:0]               slave_read_data_valid,
  output logic                                error,
  output logic [$clog2(MAX_OUTSTANDING):0]    outstanding
);

  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int OW = PW + 1;

  // Address decode. The slave index is carried one-hot throughout, which keeps
  // every select a plain AND/OR and avoids index-width mismatches for any NUM_SLAVES.
  logic                  mapped;
  logic [NUM_SLAVES-1:0] hit_oh;
  logic [31:0]           sel_mask;
  logic                  sel_ready;

  always_comb begin
    mapped   = 1'b0;
    hit_oh   = '0;
    sel_mask = '0;
    // Walk from the top down so the lowest-index hit is the one that sticks.
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        mapped    = 1'b1;
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
        sel_mask  = SLAVE_MASK[32*i +: 32];
      end
    end
  end

  assign sel_ready = |(slave_ready & hit_oh);

  // Read-tracking FIFO: one tag per accepted read, {unmapped flag, one-hot slave}.
  logic                  fifo_unm [MAX_OUTSTANDING];
  logic [NUM_SLAVES-1:0] fifo_oh  [MAX_OUTSTANDING];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  head_unm;
  logic [NUM_SLAVES-1:0] head_oh;

  assign full     = (outstanding == OW'(MAX_OUTSTANDING));
  assign empty    = (outstanding == '0);
  assign head_unm = fifo_unm[rd_ptr];
  assign head_oh  = fifo_oh[rd_ptr];

  // Master-side handshake. Full is taken from the registered count only, so a
  // pop in the same cycle does not reopen ready until the next cycle.
  always_comb begin
    if (write_req)
      ready = mapped ? sel_ready : 1'b1;
    else if (read_req)
      ready = mapped ? (sel_ready & ~full) : ~full;
    else
      ready = mapped ? sel_ready : 1'b1;
  end

  logic push;
  assign push = read_req & ~write_req & ready;

  // Slave-side request fan-out.
  assign slave_addr        = mapped ? (addr & ~sel_mask) : addr;
  assign slave_write_data  = write_data;
  assign slave_byte_enable = byte_enable;
  assign slave_write_req   = (mapped & write_req) ? hit_oh : '0;
  assign slave_read_req    = (mapped & read_req & ~write_req & ~full) ? hit_oh : '0;

  // Response path: only the head's slave may answer; an unmapped head answers
  // itself with zero data.
  logic        pop;
  logic [31:0] rsp_data;
  logic        stray;

  always_comb begin
    pop      = 1'b0;
    rsp_data = '0;
    if (!empty) begin
      if (head_unm) begin
        pop = 1'b1;
      end else begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (head_oh[i] && slave_read_data_valid[i]) begin
            pop      = 1'b1;
            rsp_data = slave_read_data[32*i +: 32];
          end
        end
      end
    end
  end

  // Any valid not belonging to a mapped head is a protocol error and is dropped.
  assign stray = |(slave_read_data_valid & ((empty | head_unm) ? '0 : ~head_oh)) |
                 ((empty | head_unm) & (|slave_read_data_valid));

  assign read_data_valid = pop;
  assign read_data       = rsp_data;

  logic err_set;
  assign err_set = stray | (pop & head_unm) | (write_req & read_req) | (write_req & ~mapped);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      error       <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_unm[i] <= 1'b0;
        fifo_oh[i]  <= '0;
      end
    end else begin
      if (push) begin
        fifo_unm[wr_ptr] <= ~mapped;
        fifo_oh[wr_ptr]  <= hit_oh;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (err_set)
        error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_router.sv
module tb_bus_router;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         ready;
  logic [31:0]  addr;
  logic [31:0]  write_data;
  logic [3:0]   byte_enable;
  logic         write_req;
  logic         read_req;
  logic [31:0]  read_data;
  logic         read_data_valid;
  logic [3:0]   slave_ready;
  logic [31:0]  slave_addr;
  logic [31:0]  slave_write_data;
  logic [3:0]   slave_byte_enable;
  logic [3:0]   slave_write_req;
  logic [3:0]   slave_read_req;
  logic [127:0] slave_read_data;
  logic [3:0]   slave_read_data_valid;
  logic         error;
  logic [2:0]   outstanding;

  int checks = 0;
  int errors = 0;

  bus_router dut (
    .clk                   (clk),
    .reset_n               (reset_n),
    .ready                 (ready),
    .addr                  (addr),
    .write_data            (write_data),
    .byte_enable           (byte_enable),
    .write_req             (write_req),
    .read_req              (read_req),
    .read_data             (read_data),
    .read_data_valid       (read_data_valid),
    .slave_ready           (slave_ready),
    .slave_addr            (slave_addr),
    .slave_write_data      (slave_write_data),
    .slave_byte_enable     (slave_byte_enable),
    .slave_write_req       (slave_write_req),
    .slave_read_req        (slave_read_req),
    .slave_read_data       (slave_read_data),
    .slave_read_data_valid (slave_read_data_valid),
    .error                 (error),
    .outstanding           (outstanding)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic drive_idle();
    write_req = 1'b0; read_req = 1'b0; addr = '0; write_data = '0; byte_enable = '0;
    slave_ready = 4'hF; slave_read_data = '0; slave_read_data_valid = '0;
  endtask

  // Leaves the bench at a falling edge with reset just released.
  task automatic do_reset();
    reset_n = 1'b0;
    drive_idle();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (read_data_valid !== 1'b0) begin errors++; $display("FAIL reset_rdv: got %b want 0", read_data_valid); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", read_data); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_write();
    do_reset();
    addr = 32'h1000_0040; write_data = 32'hCAFE_F00D; byte_enable = 4'hF;
    write_req = 1'b1; slave_ready = 4'b0010;
    #1;
    checks++; if (slave_write_req !== 4'b0010) begin errors++; $display("FAIL wr_strobe: got %b want 0010", slave_write_req); end
    checks++; if (slave_addr !== 32'h0000_0040) begin errors++; $display("FAIL wr_addr: got %h want 00000040", slave_addr); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b want 1", ready); end
    checks++; if (slave_write_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_data: got %h want cafef00d", slave_write_data); end
    checks++; if (slave_byte_enable !== 4'hF) begin errors++; $display("FAIL wr_be: got %h want f", slave_byte_enable); end
    checks++; if (slave_read_req !== 4'b0000) begin errors++; $display("FAIL wr_rdreq: got %b want 0000", slave_read_req); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL wr_error: got %b want 0", error); end
  endtask

  task automatic test_order();
    do_reset();
    read_req = 1'b1; addr = 32'h0000_0000;
    #1;
    checks++; if (slave_read_req !== 4'b0001) begin errors++; $display("FAIL ord_req0: got %b want 0001", slave_read_req); end
    @(negedge clk);
    addr = 32'h2000_0004;
    #1;
    checks++; if (slave_read_req !== 4'b0100) begin errors++; $display("FAIL ord_req2: got %b want 0100", slave_read_req); end
    checks++; if (slave_addr !== 32'h0000_0004) begin errors++; $display("FAIL ord_addr2: got %h want 00000004", slave_addr); end
    @(negedge clk);
    read_req = 1'b0; slave_read_data_valid = 4'b0100; slave_read_data[95:64] = 32'hDEAD_BEEF;
    #1;
    checks++; if (read_data_valid !== 1'b0) begin errors++; $display("FAIL ord_stray_rdv: got %b want 0", read_data_valid); end
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL ord_out2: got %0d want 2", outstanding); end
    @(negedge clk);
    slave_read_data_valid = 4'b0001; slave_read_data[31:0] = 32'h1111_1111;
    #1;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL ord_error: got %b want 1", error); end
    checks++; if (read_data_valid !== 1'b1) begin errors++; $display("FAIL ord_rdv0: got %b want 1", read_data_valid); end
    checks++; if (read_data !== 32'h1111_1111) begin errors++; $display("FAIL ord_data0: got %h want 11111111", read_data); end
    @(negedge clk);
    slave_read_data_valid = 4'b0100; slave_read_data[95:64] = 32'h2222_2222;
    #1;
    checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL ord_out1: got %0d want 1", outstanding); end
    checks++; if (read_data !== 32'h2222_2222) begin errors++; $display("FAIL ord_data2: got %h want 22222222", read_data); end
    @(negedge clk);
    slave_read_data_valid = '0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL ord_out0: got %0d want 0", outstanding); end
  endtask

  task automatic test_full();
    do_reset();
    read_req = 1'b1; addr = 32'h3000_0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL full_fill_ready%0d: got %b want 1", i, ready); end
      @(negedge clk);
    end
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_out4: got %0d want 4", outstanding); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", ready); end
    checks++; if (slave_read_req !== 4'b0000) begin errors++; $display("FAIL full_rdreq: got %b want 0000", slave_read_req); end
    @(negedge clk);
    slave_read_data_valid = 4'b1000; slave_read_data[127:96] = 32'h3333_0000;
    #1;
    checks++; if (read_data_valid !== 1'b1) begin errors++; $display("FAIL full_pop_rdv: got %b want 1", read_data_valid); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL full_no_bypass: got %b want 0", ready); end
    @(negedge clk);
    slave_read_data_valid = '0;
    #1;
    checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL full_out3: got %0d want 3", outstanding); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b want 1", ready); end
    @(negedge clk);
    read_req = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d want 4", outstanding); end
    for (int i = 0; i < 4; i++) begin
      slave_read_data_valid = 4'b1000; slave_read_data[127:96] = 32'hA000_0000 + i;
      #1;
      checks++; if (read_data !== 32'hA000_0000 + i) begin errors++; $display("FAIL full_drain%0d: got %h want %h", i, read_data, 32'hA000_0000 + i); end
      @(negedge clk);
    end
    slave_read_data_valid = '0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL full_empty: got %0d want 0", outstanding); end
  endtask

  task automatic test_unmapped();
    do_reset();
    read_req = 1'b1; addr = 32'h4000_0000;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL unm_ready: got %b want 1", ready); end
    checks++; if (slave_read_req !== 4'b0000) begin errors++; $display("FAIL unm_rdreq: got %b want 0000", slave_read_req); end
    @(negedge clk);
    read_req = 1'b0;
    #1;
    checks++; if (read_data_valid !== 1'b1) begin errors++; $display("FAIL unm_rdv: got %b want 1", read_data_valid); end
    checks++; if (read_data !== 32'h0) begin errors++; $display("FAIL unm_data: got %h want 0", read_data); end
    @(negedge clk);
    #1;
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL unm_error: got %b want 1", error); end
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL unm_out: got %0d want 0", outstanding); end
    checks++; if (read_data_valid !== 1'b0) begin errors++; $display("FAIL unm_rdv_off: got %b want 0", read_data_valid); end
  endtask

  task automatic test_wr_rd();
    do_reset();
    write_req = 1'b1; read_req = 1'b1; addr = 32'h0000_0010;
    #1;
    checks++; if (slave_write_req !== 4'b0001) begin errors++; $display("FAIL wrrd_wstrobe: got %b want 0001", slave_write_req); end
    checks++; if (slave_read_req !== 4'b0000) begin errors++; $display("FAIL wrrd_rstrobe: got %b want 0000", slave_read_req); end
    @(negedge clk);
    drive_idle();
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL wrrd_out: got %0d want 0", outstanding); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL wrrd_error: got %b want 1", error); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    write_req = 1'b1; addr = 32'h5000_0000;
    #1;
    checks++; if (slave_write_req !== 4'b0000) begin errors++; $display("FAIL mid_unm_wr: got %b want 0000", slave_write_req); end
    @(negedge clk);
    write_req = 1'b0; read_req = 1'b1; addr = 32'h1000_0000;
    @(negedge clk);
    @(negedge clk);
    read_req = 1'b0; slave_read_data_valid = 4'b0010; slave_read_data[63:32] = 32'h4444_4444;
    #1;
    checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL mid_out2: got %0d want 2", outstanding); end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL mid_err_pre: got %b want 1", error); end
    checks++; if (read_data_valid !== 1'b1) begin errors++; $display("FAIL mid_rdv_pre: got %b want 1", read_data_valid); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL mid_out0: got %0d want 0", outstanding); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL mid_err0: got %b want 0", error); end
    checks++; if (read_data_valid !== 1'b0) begin errors++; $display("FAIL mid_rdv0: got %b want 0", read_data_valid); end
    slave_read_data_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reference model: queue of issued reads (slave number, 4 = unmapped).
  // Slaves answer only for the head read, so errors come from unmapped traffic only.
  task automatic test_random();
    int          q[$];
    bit          err_m;
    int          op, nib, s;
    bit          mapped_m, full_m, resp, exp_ready;
    logic [31:0] exp_data, exp_saddr;
    logic [3:0]  exp_swr, exp_srr;
    do_reset();
    err_m = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      op  = $urandom_range(0, 3);
      nib = $urandom_range(0, 5);
      write_req = (op == 1);
      read_req  = (op >= 2);
      addr = {4'(nib), 28'($urandom)};
      slave_ready = 4'($urandom);
      slave_read_data = {$urandom, $urandom, $urandom, $urandom};
      slave_read_data_valid = '0;
      resp = 1'b0; exp_data = '0;
      if (q.size() > 0) begin
        if (q[0] == 4) resp = 1'b1;
        else if ($urandom_range(0, 1) == 1) begin
          resp = 1'b1;
          slave_read_data_valid = 4'(1 << q[0]);
          exp_data = slave_read_data[q[0]*32 +: 32];
        end
      end
      mapped_m = (nib < 4);
      s = mapped_m ? nib : 0;
      full_m = (q.size() == 4);
      if (write_req) exp_ready = mapped_m ? slave_ready[s] : 1'b1;
      else if (read_req) exp_ready = mapped_m ? (slave_ready[s] & !full_m) : !full_m;
      else exp_ready = mapped_m ? slave_ready[s] : 1'b1;
      exp_swr = (write_req && mapped_m) ? 4'(1 << s) : 4'b0;
      exp_srr = (read_req && mapped_m && !full_m) ? 4'(1 << s) : 4'b0;
      exp_saddr = mapped_m ? {4'h0, addr[27:0]} : addr;
      #1;
      checks++; if (ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, ready, exp_ready); end
      checks++; if (slave_write_req !== exp_swr) begin errors++; $display("FAIL rnd_swr c%0d: got %b want %b", cyc, slave_write_req, exp_swr); end
      checks++; if (slave_read_req !== exp_srr) begin errors++; $display("FAIL rnd_srr c%0d: got %b want %b", cyc, slave_read_req, exp_srr); end
      checks++; if (slave_addr !== exp_saddr) begin errors++; $display("FAIL rnd_saddr c%0d: got %h want %h", cyc, slave_addr, exp_saddr); end
      checks++; if (read_data_valid !== resp) begin errors++; $display("FAIL rnd_rdv c%0d: got %b want %b", cyc, read_data_valid, resp); end
      checks++; if (read_data !== exp_data) begin errors++; $display("FAIL rnd_rdata c%0d: got %h want %h", cyc, read_data, exp_data); end
      checks++; if (outstanding !== 3'(q.size())) begin errors++; $display("FAIL rnd_out c%0d: got %0d want %0d", cyc, outstanding, q.size()); end
      checks++; if (error !== err_m) begin errors++; $display("FAIL rnd_error c%0d: got %b want %b", cyc, error, err_m); end
      if (resp) begin
        if (q[0] == 4) err_m = 1'b1;
        void'(q.pop_front());
      end
      if (write_req && !mapped_m) err_m = 1'b1;
      if (read_req && !write_req && exp_ready) q.push_back(mapped_m ? s : 4);
      @(negedge clk);
    end
  endtask

  initial begin
    drive_idle();
    @(negedge clk);
    test_reset();
    test_write();
    test_order();
    test_full();
    test_unmapped();
    test_wr_rd();
    test_reset_mid();
    test_random();
    drive_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_router.md
BUS_ROUTER -- requirements
Module: bus_router

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave ports (legal 1..8).
REQ-002 SHALL have parameter SLAVE_BASE, default {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, per-slave region base, slave i at bits [32i+31:32i].
REQ-003 SHALL have parameter SLAVE_MASK, default {4{32'hF000_0000}}, per-slave decode mask, same packing.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, read-tracking FIFO depth (power of 2, 2..16).
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  clock, rising edge; reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have master ports: ready out 1; addr in 32; write_data in 32; byte_enable in 4; write_req in 1; read_req in 1; read_data out 32; read_data_valid out 1.
REQ-007 SHALL have slave ports: slave_ready in NUM_SLAVES; slave_addr out 32 (shared); slave_write_data out 32 (shared); slave_byte_enable out 4 (shared); slave_write_req out NUM_SLAVES; slave_read_req out NUM_SLAVES; slave_read_data in 32*NUM_SLAVES; slave_read_data_valid in NUM_SLAVES.
REQ-008 SHALL have status ports: error out 1 (sticky protocol/decode error); outstanding out $clog2(MAX_OUTSTANDING)+1 (reads in flight).

Function
REQ-009 SHALL decode hit_i = ((addr & SLAVE_MASK_i) == SLAVE_BASE_i); lowest index among hits selected; no hit = unmapped.
REQ-010 SHALL drive slave_addr = addr & ~SLAVE_MASK_sel (region-relative offset); addr unchanged when unmapped; write_data/byte_enable passed through combinationally.
REQ-011 SHALL assert slave_write_req[sel] = write_req when mapped; all other slave_write_req bits 0.
REQ-012 SHALL assert slave_read_req[sel] = read_req & ~write_req & ~full when mapped; gated off while FIFO full.
REQ-013 SHALL drive ready: mapped write = slave_ready[sel]; mapped read = slave_ready[sel] & ~full; unmapped write = 1; unmapped read = ~full; no request = slave_ready[sel] (1 if unmapped).
REQ-014 SHALL accept a read when read_req & ready & ~write_req; on acceptance push tag {unmapped flag, slave index} into FIFO at the clock edge.
REQ-015 SHALL hold full = (outstanding == MAX_OUTSTANDING); ready stays low when full even if a pop occurs that cycle (no push-on-pop bypass).
REQ-016 SHALL return data strictly in issue order: when FIFO head is mapped slave h and slave_read_data_valid[h]=1, drive read_data = slave_read_data[h], read_data_valid = 1 combinationally, and pop.
REQ-017 SHALL, when FIFO head is unmapped, drive read_data = 32'h0, read_data_valid = 1 for one cycle and pop (latency 1 cycle after acceptance), and set error.
REQ-018 SHALL ignore slave_read_data_valid from any slave other than the head's (or when FIFO empty) and set error.
REQ-019 SHALL treat write_req & read_req in same cycle as write only; read not issued; error set.
REQ-020 SHALL discard unmapped writes (no slave strobe) and set error on acceptance.
REQ-021 SHALL update outstanding as +1 on push, -1 on pop, unchanged on simultaneous push and pop; FIFO pointers wrap modulo MAX_OUTSTANDING.
REQ-022 SHALL keep error set until reset; no other clear.
REQ-023 SHALL drive read_data = 32'h0 whenever read_data_valid = 0.

Reset
REQ-024 SHALL, on reset_n low (any time, including mid-transfer), asynchronously empty the FIFO, clear outstanding to 0 and error to 0; read_data_valid = 0 while reset_n low.
REQ-025 SHALL discard in-flight reads across reset; slave responses arriving after reset release fall under REQ-018.

Verification
REQ-026 SHALL pass: write addr 32'h1000_0040, data 32'hCAFE_F00D, be 4'hF, slave_ready[1]=1 -> slave_write_req=4'b0010, slave_addr=32'h0000_0040, ready=1, error=0.
REQ-027 SHALL pass: reads to 0x0000_0000 then 0x2000_0004; slave2 valid before slave0 -> slave2 response ignored, error=1; slave0 then returns 32'h1111_1111, read_data=32'h1111_1111, outstanding 2->1.
REQ-028 SHALL pass: 4 reads to slave 3 with no responses -> outstanding=4, ready=0 on 5th read, slave_read_req=0; one response -> outstanding 3, ready=1 next cycle.
REQ-029 SHALL pass: with SLAVE_MASK_3 changed to 32'hFFFF_0000 (e.g. SLAVE_BASE_3=32'h3000_0000), read addr 32'h4000_0000 -> ready=1, next cycle read_data_valid=1, read_data=0, error=1.
REQ-030 SHALL pass: write_req and read_req both high to slave 0 -> only slave_write_req[0]=1, outstanding stays 0, error=1.
REQ-031 SHALL pass: 2 reads outstanding, reset_n pulsed low mid-cycle -> outstanding=0, error=0, read_data_valid=0 immediately, without waiting for a clock edge.
